// File: rtl/p_fxp_seq_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : p_fxp_seq_acc_pkg
//  Purpose  : Shared types for the sequential fixed-point accumulator stage:
//             the dconf_t fixed-point format descriptor, the accumulator FSM
//             state type and helpers for the representable range of a format.
//  Revision : 1.0 - initial release
// ============================================================================
package p_fxp_seq_acc_pkg;

  // Fixed-point format descriptor: signedness, fraction bits, total width.
  typedef struct packed {
    logic       sign;
    logic [7:0] frac;
    logic [7:0] prec;
  } dconf_t;

  // Default datapath format: signed Q7.8 in 16 bits.
  localparam dconf_t C_DEF_DCONF_FXP = '{sign: 1'b1, frac: 8'd8, prec: 8'd16};

  // Accumulator FSM: gathering beats, or presenting a finished result.
  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } p_acc_state_t;

  // Largest value of a format, as a 64-bit pattern (widths up to 63 bits).
  function automatic logic [63:0] f_prec_max(input logic sign, input int prec);
    return sign ? ((64'd1 << (prec - 1)) - 64'd1) : ((64'd1 << prec) - 64'd1);
  endfunction

  // Smallest value of a format, as a 64-bit two's-complement pattern.
  function automatic logic [63:0] f_prec_min(input logic sign, input int prec);
    return sign ? ~((64'd1 << (prec - 1)) - 64'd1) : 64'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p_fxp_seq_acc_if.sv
`default_nettype none
// ============================================================================
//  Module   : p_fxp_seq_acc_if
//  Purpose  : Beat-in / result-out bus of the sequential accumulator. The
//             slave modport is the accumulator side, master the driver side.
//  Revision : 1.0 - initial release
// ============================================================================
interface p_fxp_seq_acc_if #(
  parameter int PREC = 16
) ();

  logic            in_valid;
  logic            in_ready;
  logic [PREC-1:0] in_data;
  logic            in_ovf;
  logic            in_last;
  logic [PREC-1:0] bias;
  logic            out_valid;
  logic            out_ready;
  logic [PREC-1:0] out_data;
  logic            out_ovf;

  modport slave (
    input  in_valid, in_data, in_ovf, in_last, bias, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, in_ovf, in_last, bias, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

endinterface
`default_nettype wire

// File: rtl/p_fxp_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : p_fxp_reduce
//  Purpose  : Combinational ACC_W -> PREC narrowing with range check. Values
//             outside the PREC format raise o_ovf and are either clamped to
//             the format limits or wrapped to the low PREC bits.
//  Config   : define P_ACC_SAT_EN to clamp; otherwise results wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module p_fxp_reduce
  import p_fxp_seq_acc_pkg::*;
#(
  parameter bit IS_SIGNED = 1'b1,
  parameter int PREC      = 16,
  parameter int ACC_W     = 20
) (
  input  wire logic [ACC_W-1:0] i_acc,
  output      logic [PREC-1:0]  o_data,
  output      logic             o_ovf
);

  logic w_in_range;

  // Signed: all bits from the PREC sign bit upward must agree.
  // Unsigned: every bit above PREC must be zero.
  assign w_in_range = IS_SIGNED ? ((&i_acc[ACC_W-1:PREC-1]) | ~(|i_acc[ACC_W-1:PREC-1]))
                                : ~(|i_acc[ACC_W-1:PREC]);

`ifdef P_ACC_SAT_EN
  localparam logic [PREC-1:0] c_max = PREC'(f_prec_max(IS_SIGNED, PREC));
  localparam logic [PREC-1:0] c_min = PREC'(f_prec_min(IS_SIGNED, PREC));

  // Clamp toward the side the accumulator overshot.
  assign o_data = w_in_range ? i_acc[PREC-1:0]
                : ((IS_SIGNED && i_acc[ACC_W-1]) ? c_min : c_max);
`else
  assign o_data = i_acc[PREC-1:0];
`endif

  assign o_ovf = ~w_in_range;

endmodule
`default_nettype wire

// File: rtl/p_fxp_seq_acc.sv
`default_nettype none
// ============================================================================
//  Module   : p_fxp_seq_acc
//  Purpose  : Accumulates a stream of adder-tree partial sums plus a bias
//             into one pre-activation value and presents it on a
//             valid/ready output, so long dot products can run in chunks.
//  Config   : P_ACC_SAT_EN selects clamping (defined) or wrapping (default)
//             of out-of-range results.
//  Revision : 1.0 - initial release
// ============================================================================
module p_fxp_seq_acc
  import p_fxp_seq_acc_pkg::*;
#(
  parameter dconf_t CONF  = C_DEF_DCONF_FXP,
  parameter int     GUARD = 4,
  parameter int     PREC  = int'(CONF.prec)   // derived, do not override
) (
  input wire logic           clk,
  input wire logic           reset_,
  p_fxp_seq_acc_if.slave     bus
);

  localparam int              ACC_W      = PREC + GUARD;
  localparam logic [GUARD:0]  c_cnt_max  = {1'b1, {GUARD{1'b0}}};
  localparam logic [GUARD:0]  c_cnt_one  = (GUARD + 1)'(1);

  // Widen a PREC-format operand to the accumulator width, same binary point.
  function automatic logic [ACC_W-1:0] f_ext(input logic [PREC-1:0] v);
    return CONF.sign ? {{GUARD{v[PREC-1]}}, v} : {{GUARD{1'b0}}, v};
  endfunction

  p_acc_state_t    r_state;
  logic [ACC_W-1:0] r_acc;
  logic            r_first;
  logic [GUARD:0]  r_beat_cnt;
  logic            r_ovf_acc;
  logic            r_out_valid;
  logic [PREC-1:0] r_out_data;
  logic            r_out_ovf;

  logic            w_in_ready;
  logic            w_fire_in;
  logic            w_fire_out;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W:0]  w_sum;
  logic [ACC_W-1:0] w_acc_new;
  logic            w_add_ovf;
  logic [GUARD:0]  w_cnt_base;
  logic            w_cnt_full;
  logic [GUARD:0]  w_cnt_new;
  logic            w_ovf_new;
  logic [PREC-1:0] w_red_data;
  logic            w_red_ovf;

  // While a result is pending, a new beat may only enter in the cycle the
  // result leaves, which gives back-to-back products without a bubble.
  assign w_in_ready = (r_state == ACC) | bus.out_ready;
  assign w_fire_in  = bus.in_valid & w_in_ready;
  assign w_fire_out = r_out_valid & bus.out_ready;

  // First beat of a product restarts from the bias instead of the old sum.
  assign w_base    = r_first ? f_ext(bus.bias) : r_acc;
  assign w_addend  = f_ext(bus.in_data);
  assign w_sum     = {1'b0, w_base} + {1'b0, w_addend};
  assign w_acc_new = w_sum[ACC_W-1:0];
  assign w_add_ovf = CONF.sign ? ((w_base[ACC_W-1] == w_addend[ACC_W-1]) &&
                                  (w_acc_new[ACC_W-1] != w_base[ACC_W-1]))
                               : w_sum[ACC_W];

  // Beat counter saturates at 2**GUARD; a beat arriving once it is full is
  // one more than the guard bits can absorb and is flagged as overflow.
  assign w_cnt_base = r_first ? '0 : r_beat_cnt;
  assign w_cnt_full = (w_cnt_base == c_cnt_max);
  assign w_cnt_new  = w_cnt_full ? w_cnt_base : (w_cnt_base + c_cnt_one);
  assign w_ovf_new  = (r_first ? 1'b0 : r_ovf_acc) | bus.in_ovf | w_add_ovf | w_cnt_full;

  p_fxp_reduce #(
    .IS_SIGNED (CONF.sign),
    .PREC      (PREC),
    .ACC_W     (ACC_W)
  ) u_reduce (
    .i_acc  (w_acc_new),
    .o_data (w_red_data),
    .o_ovf  (w_red_ovf)
  );

  // FSM, accumulator and registered result; an accepted last beat overrides
  // the retirement of the previous result in the same cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_beat_cnt  <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_fire_out) begin
        r_state     <= ACC;
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_beat_cnt  <= '0;
      end
      if (w_fire_in) begin
        r_acc      <= w_acc_new;
        r_beat_cnt <= w_cnt_new;
        r_ovf_acc  <= w_ovf_new;
        r_first    <= bus.in_last;
        if (bus.in_last) begin
          r_state     <= OUT;
          r_out_valid <= 1'b1;
          r_out_data  <= w_red_data;
          r_out_ovf   <= w_ovf_new | w_red_ovf;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_p_fxp_seq_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p_fxp_seq_acc
//  Purpose  : Directed self-checking bench for p_fxp_seq_acc (signed Q7.8,
//             GUARD=4). Inputs change and outputs are sampled on the falling
//             clock edge. Honours P_ACC_SAT_EN for the range test.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_p_fxp_seq_acc;

  logic clk;
  logic reset_;
  int   n_cmp;
  int   n_err;

  p_fxp_seq_acc_if #(.PREC(16)) bus ();

  p_fxp_seq_acc #(.GUARD(4)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one beat, let the next rising edge take it, then go idle.
  task automatic drive_beat(input logic [15:0] d, input logic ovf, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ovf   = ovf;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_ovf   = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
      n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b want 0", bus.out_ovf); end
    end
    bus.in_valid = 1'b0;
    reset_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sum();
    bus.out_ready = 1'b1;
    bus.bias = 16'h0100;
    drive_beat(16'h0080, 1'b0, 1'b0);
    drive_beat(16'h0080, 1'b0, 1'b0);
    drive_beat(16'h0100, 1'b0, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sum_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'h0300) begin n_err++; $display("FAIL sum_data: got %h want 0300", bus.out_data); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL sum_ovf: got %b want 0", bus.out_ovf); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sum_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_range();
    logic [15:0] exp_data;
`ifdef P_ACC_SAT_EN
    exp_data = 16'h7FFF;
`else
    exp_data = 16'h8000;
`endif
    bus.bias = 16'h7F00;
    drive_beat(16'h0080, 1'b0, 1'b0);
    drive_beat(16'h0080, 1'b0, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL range_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== exp_data) begin n_err++; $display("FAIL range_data: got %h want %h", bus.out_data, exp_data); end
    n_cmp++; if (bus.out_ovf !== 1'b1) begin n_err++; $display("FAIL range_ovf: got %b want 1", bus.out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.bias = 16'h0000;
    drive_beat(16'h0005, 1'b0, 1'b1);
    // A competing beat waits at the input the whole time the result stalls.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0009;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.out_data !== 16'h0005) begin n_err++; $display("FAIL bp_data[%0d]: got %h want 0005", i, bus.out_data); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    n_cmp++; if (bus.out_data !== 16'h0005) begin n_err++; $display("FAIL bp_release_data: got %h want 0005", bus.out_data); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_fire_once: got %b want 0", bus.out_valid); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_stay_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    vals[0] = 16'h0001;
    vals[1] = 16'h0002;
    vals[2] = 16'h0003;
    bus.out_ready = 1'b1;
    bus.bias = 16'h0000;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_ovf   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = vals[i];
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.out_data !== vals[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.out_data, vals[i]); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ovf();
    bus.out_ready = 1'b1;
    bus.bias = 16'h0000;
    drive_beat(16'h0010, 1'b0, 1'b0);
    drive_beat(16'h0020, 1'b1, 1'b0);
    drive_beat(16'h0030, 1'b0, 1'b1);
    n_cmp++; if (bus.out_data !== 16'h0060) begin n_err++; $display("FAIL ovf_tree_data: got %h want 0060", bus.out_data); end
    n_cmp++; if (bus.out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_tree_flag: got %b want 1", bus.out_ovf); end
    @(negedge clk);
    drive_beat(16'h0001, 1'b0, 1'b0);
    drive_beat(16'h0002, 1'b0, 1'b1);
    n_cmp++; if (bus.out_data !== 16'h0003) begin n_err++; $display("FAIL ovf_clean_data: got %h want 0003", bus.out_data); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clean_flag: got %b want 0", bus.out_ovf); end
    @(negedge clk);
    for (int i = 0; i < 17; i++) drive_beat(16'h0000, 1'b0, (i == 16));
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_cnt_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'h0000) begin n_err++; $display("FAIL ovf_cnt_data: got %h want 0000", bus.out_data); end
    n_cmp++; if (bus.out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_cnt_flag: got %b want 1", bus.out_ovf); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.bias = 16'h0100;
    drive_beat(16'h0010, 1'b0, 1'b0);
    drive_beat(16'h0020, 1'b0, 1'b0);
    reset_ = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid_in_reset: got %b want 0", bus.out_valid); end
    reset_ = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid_after: got %b want 0", bus.out_valid); end
    bus.bias = 16'h0000;
    drive_beat(16'h0005, 1'b0, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_next_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'h0005) begin n_err++; $display("FAIL rmid_next_data: got %h want 0005", bus.out_data); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_err++; $display("FAIL rmid_next_ovf: got %b want 0", bus.out_ovf); end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_ovf    = 1'b0;
    bus.in_last   = 1'b0;
    bus.bias      = 16'h0000;
    bus.out_ready = 1'b1;
    #2;
    test_reset();
    test_sum();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_ovf();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
